exp_ctrl: RTL and testbench

Exception/trap sequencer that drives the exception side of the CSR unit. It accepts synchronous exceptions, external interrupts and exception returns from the pipeline, then drains and flushes the pipeline. It pulses save_exp or restore_exp toward the CSR unit with the cause and PC, then redirects fetch to the trap vector or to the saved mepc. It sits between the MEM-stage exception detector, the CSR unit and the IF-stage PC mux.

---
 rtl/exp_ctrl.sv | 123 ++++++++++++
 tb/tb_exp_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/exp_ctrl.sv
// Exception/trap sequencer: accepts exceptions, interrupts and exception
// returns from the pipeline, drains/flushes it, pulses the CSR save/restore
// strobes and redirects fetch to the trap vector or to the saved mepc.
module exp_ctrl #(
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          DRAIN_CYCLES = 2,
  parameter logic [5:0]  IRQ_CODE     = 6'h2B
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exp_req,
  input  logic [5:0]  exp_code_req,
  input  logic [31:0] exp_pc,
  input  logic        eret_req,
  input  logic        irq,
  input  logic [31:0] irq_pc,
  input  logic        mstatus_ie,
  input  logic [31:0] mepc_in,
  output logic        save_exp,
  output logic        restore_exp,
  output logic [5:0]  exp_code,
  output logic [31:0] mepc,
  output logic        flush,
  output logic        stall,
  output logic        new_pc_en,
  output logic [31:0] new_pc,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_SAVE, S_VECTOR, S_RESTORE, S_RETURN
  } state_t;

  // Counter is loaded with D-1 so DRAIN lasts exactly D cycles.
  localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [5:0]  code_q;
  logic [31:0] pc_q;

  // Sequencer: requests are only looked at in IDLE; anything arriving while
  // busy belongs to a younger instruction that is being flushed anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      pc_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (exp_req) begin
            code_q  <= exp_code_req;
            pc_q    <= exp_pc;
            cnt_q   <= CNT_INIT;
            state_q <= S_DRAIN;
          end else if (eret_req) begin
            state_q <= S_RESTORE;
          end else if (irq && mstatus_ie) begin
            code_q  <= IRQ_CODE;
            pc_q    <= irq_pc;
            cnt_q   <= CNT_INIT;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (cnt_q == 4'd0) state_q <= S_SAVE;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        S_SAVE:    state_q <= S_VECTOR;
        S_VECTOR:  state_q <= S_IDLE;
        S_RESTORE: state_q <= S_RETURN;
        S_RETURN:  state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  // Moore output decode from the registered state; new_pc in RETURN follows
  // mepc_in live so a CSR write landing during RESTORE is honoured.
  always_comb begin
    save_exp    = 1'b0;
    restore_exp = 1'b0;
    flush       = 1'b0;
    stall       = 1'b0;
    new_pc_en   = 1'b0;
    new_pc      = '0;
    busy        = (state_q != S_IDLE);
    case (state_q)
      S_DRAIN: begin
        flush = 1'b1;
        stall = 1'b1;
      end
      S_SAVE: begin
        save_exp = 1'b1;
        flush    = 1'b1;
        stall    = 1'b1;
      end
      S_VECTOR: begin
        flush     = 1'b1;
        new_pc_en = 1'b1;
        new_pc    = TRAP_VECTOR;
      end
      S_RESTORE: begin
        restore_exp = 1'b1;
        flush       = 1'b1;
        stall       = 1'b1;
      end
      S_RETURN: begin
        flush     = 1'b1;
        new_pc_en = 1'b1;
        new_pc    = mepc_in;
      end
      default: ;
    endcase
  end

  // Captured cause/PC are held between traps; consumers qualify with save_exp.
  assign exp_code = code_q;
  assign mepc     = pc_q;

endmodule

// File: tb/tb_exp_ctrl.sv
// Scoreboard bench for exp_ctrl: a transaction-level model predicts the
// pulses and busy/stall windows; a negedge monitor pops and compares.
module tb_exp_ctrl;

  localparam int          D    = 2;
  localparam logic [31:0] TVEC = 32'h0000_0100;
  localparam logic [5:0]  IRQC = 6'h2B;
  localparam int          NCYC = 8192;

  logic        clk = 1'b0;
  logic        reset, exp_req, eret_req, irq, mstatus_ie;
  logic [5:0]  exp_code_req;
  logic [31:0] exp_pc, irq_pc, mepc_in;
  logic        save_exp, restore_exp, flush, stall, new_pc_en, busy;
  logic [5:0]  exp_code;
  logic [31:0] mepc, new_pc;

  exp_ctrl #(.TRAP_VECTOR(TVEC), .DRAIN_CYCLES(D), .IRQ_CODE(IRQC)) dut (
    .clk(clk), .reset(reset),
    .exp_req(exp_req), .exp_code_req(exp_code_req), .exp_pc(exp_pc),
    .eret_req(eret_req), .irq(irq), .irq_pc(irq_pc),
    .mstatus_ie(mstatus_ie), .mepc_in(mepc_in),
    .save_exp(save_exp), .restore_exp(restore_exp),
    .exp_code(exp_code), .mepc(mepc), .flush(flush), .stall(stall),
    .new_pc_en(new_pc_en), .new_pc(new_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam int K_SAVE = 0, K_VEC = 1, K_RST = 2, K_RET = 3;
  typedef struct {
    int          cyc;
    int          kind;
    logic [5:0]  code;
    logic [31:0] pc;
  } ev_t;

  ev_t  q[$];
  bit   exp_busy  [NCYC];
  bit   exp_stall [NCYC];
  int   cyc      = 0;   // cycle c is the interval following rising edge c
  int   busy_end = -1;  // last cycle the model expects the block to be busy
  int   checks   = 0;
  int   errors   = 0;
  bit   done     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input int k, input logic [5:0] code, input logic [31:0] pc);
    ev_t e;
    e.cyc = c; e.kind = k; e.code = code; e.pc = pc;
    q.push_back(e);
  endtask

  task automatic mark(input int from, input int upto, input bit st);
    for (int c = from; c <= upto; c++) begin
      if (c < NCYC) begin
        exp_busy[c] = 1'b1;
        if (st) exp_stall[c] = 1'b1;
      end
    end
  endtask

  // Reference: decide what happens at the coming edge e from the request
  // rules, then schedule the resulting pulses and busy/stall windows.
  task automatic model_edge();
    int e;
    e = cyc + 1;
    if (reset) begin
      while (q.size() > 0 && q[$].cyc >= e) void'(q.pop_back());
      for (int c = e; c < e + D + 4 && c < NCYC; c++) begin
        exp_busy[c] = 1'b0; exp_stall[c] = 1'b0;
      end
      busy_end = e - 1;
    end else if (e - 1 > busy_end) begin
      if (exp_req || (!eret_req && irq && mstatus_ie)) begin
        push(e + D,     K_SAVE, exp_req ? exp_code_req : IRQC, exp_req ? exp_pc : irq_pc);
        push(e + D + 1, K_VEC, '0, TVEC);
        mark(e, e + D, 1'b1);
        mark(e + D + 1, e + D + 1, 1'b0);
        busy_end = e + D + 1;
      end else if (eret_req) begin
        push(e,     K_RST, '0, '0);
        push(e + 1, K_RET, '0, '0);
        mark(e, e, 1'b1);
        mark(e + 1, e + 1, 1'b0);
        busy_end = e + 1;
      end
    end
  endtask

  // One clock: model the coming edge, advance, then emulate the CSR unit's
  // IE update from the pulse seen just before the edge.
  task automatic tick();
    logic s, r;
    @(negedge clk);
    s = save_exp;
    r = restore_exp;
    model_edge();
    @(posedge clk);
    cyc++;
    #1;
    if (s)      mstatus_ie = 1'b0;
    else if (r) mstatus_ie = 1'b1;
    mepc_in = $urandom;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle_inputs();
    exp_req = 1'b0; eret_req = 1'b0; reset = 1'b0;
  endtask

  // Monitor: compare windows every cycle and pop an expected pulse when due.
  always @(negedge clk) begin
    ev_t ev;
    if (cyc >= 1 && !done) begin
      chk("busy",  {31'b0, busy},  {31'b0, exp_busy[cyc]});
      chk("flush", {31'b0, flush}, {31'b0, exp_busy[cyc]});
      chk("stall", {31'b0, stall}, {31'b0, exp_stall[cyc]});
      while (q.size() > 0 && q[0].cyc < cyc) begin
        ev = q.pop_front();
        chk("missed_event_kind", 32'hFFFF_FFFF, ev.kind);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        ev = q.pop_front();
        case (ev.kind)
          K_SAVE: begin
            chk("save_pulses", {29'b0, save_exp, restore_exp, new_pc_en}, 32'd4);
            chk("save_code", {26'b0, exp_code}, {26'b0, ev.code});
            chk("save_mepc", mepc, ev.pc);
          end
          K_VEC: begin
            chk("vec_pulses", {29'b0, save_exp, restore_exp, new_pc_en}, 32'd1);
            chk("vec_pc", new_pc, TVEC);
          end
          K_RST: begin
            chk("rst_pulses", {29'b0, save_exp, restore_exp, new_pc_en}, 32'd2);
            chk("rst_newpc", new_pc, 32'd0);
          end
          default: begin
            chk("ret_pulses", {29'b0, save_exp, restore_exp, new_pc_en}, 32'd1);
            chk("ret_pc", new_pc, mepc_in);
          end
        endcase
      end else begin
        chk("no_pulse", {29'b0, save_exp, restore_exp, new_pc_en}, 32'd0);
        chk("newpc_dflt", new_pc, 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b1; exp_req = 1'b0; eret_req = 1'b0; irq = 1'b0;
    mstatus_ie = 1'b0; exp_code_req = '0; exp_pc = '0; irq_pc = '0;
    mepc_in = '0;
    ticks(3);
    chk("rst_code", {26'b0, exp_code}, 32'd0);
    chk("rst_mepc", mepc, 32'd0);
    idle_inputs();
    ticks(2);

    // Plain exception entry.
    exp_req = 1'b1; exp_code_req = 6'h02; exp_pc = 32'h0000_0040;
    tick(); idle_inputs(); ticks(6);

    // Exception return.
    eret_req = 1'b1;
    tick(); idle_inputs(); ticks(4);

    // Interrupt taken once; CSR drops IE on save, irq stays high.
    irq = 1'b1; irq_pc = 32'h0000_0080; mstatus_ie = 1'b1;
    ticks(15);
    irq = 1'b0; ticks(2);

    // Masked interrupt stays pending, then IE unmasks it.
    irq = 1'b1; mstatus_ie = 1'b0; ticks(20);
    mstatus_ie = 1'b1; tick(); ticks(8);
    irq = 1'b0; ticks(2);

    // exp_req beats eret_req; a second exp_req during DRAIN is ignored.
    exp_req = 1'b1; eret_req = 1'b1; exp_code_req = 6'h05; exp_pc = 32'h0000_1234;
    tick(); eret_req = 1'b0; exp_code_req = 6'h07; exp_pc = 32'hDEAD_BEEF;
    tick(); idle_inputs(); ticks(6);

    // Reset during the first DRAIN cycle abandons the sequence.
    exp_req = 1'b1; exp_code_req = 6'h0C; exp_pc = 32'h0000_2000;
    tick(); exp_req = 1'b0; reset = 1'b1;
    tick(); reset = 1'b0; ticks(8);
    exp_req = 1'b1; exp_code_req = 6'h0D; exp_pc = 32'h0000_3000;
    tick(); idle_inputs(); ticks(6);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 99) == 0);
      exp_req      = ($urandom_range(0, 9) == 0);
      exp_code_req = 6'($urandom);
      exp_pc       = $urandom;
      eret_req     = ($urandom_range(0, 14) == 0);
      irq_pc       = $urandom;
      if ($urandom_range(0, 19) == 0) irq = ~irq;
      if ($urandom_range(0, 29) == 0) mstatus_ie = 1'b1;
      tick();
    end

    idle_inputs(); irq = 1'b0;
    ticks(D + 6);
    chk("queue_drained", q.size(), 32'd0);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
